approx_mul_err_monitor: RTL
===========================

Name: approx_mul_err_monitor

Overview:
- Synthesizable error-statistics collector for the approximate recursive multipliers, for FPGA-accelerated error characterisation in place of exhaustive simulation.
- Consumes a valid/ready stream of operand pairs with the DUT's approximate product and recomputes the exact product internally.
- Accumulates sample count, error count, sum of error distances and maximum error distance, and reports done after the last sample drains.

Parameters:
- W, 16, operand width; product width is 2W.
- CNT_W, 33, width of sample and error counters; 2^32 samples must not overflow.
- SUM_W, 64, width of the error-distance accumulator.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous clear of statistics and pipeline; return to IDLE.
- s_valid  in  1  input sample valid.
- s_ready  out  1  monitor can accept a sample.
- s_a  in  W  operand a.
- s_b  in  W  operand b.
- s_y  in  2W  approximate product from the DUT.
- s_last  in  1  marks the final sample of a run.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- sample_count  out  CNT_W  samples accumulated.
- err_count  out  CNT_W  samples with s_y != s_a*s_b.
- sum_ed  out  SUM_W  sum of |exact - y|, saturating.
- max_ed  out  2W  largest |exact - y| seen.
- sat  out  1  sticky; sum_ed or a counter has saturated.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: all outputs 0, except s_ready=1. FSM=IDLE, pipeline valid bits 0.
- Transfer rule: a sample transfers on a clk edge where s_valid and s_ready are both 1.
- s_ready = (state is IDLE or RUN) and not clear. Upstream may hold s_valid with no combinational path from s_ready.
- Pipeline, fixed and with no stalls:
  - S1 registers a, b, y, last.
  - S2 registers exact = a*b (2W unsigned) and y.
  - S3 computes ed = |exact - y| and neq = (ed != 0), then updates the statistics registers.
- Latency: statistics reflect a sample exactly 3 cycles after its transfer edge.
- Accumulation in S3:
  - sample_count += 1.
  - err_count += neq.
  - sum_ed += ed, zero-extended.
  - max_ed = max(max_ed, ed).
- Saturation:
  - Any counter or sum that would exceed all-ones holds at all-ones and sets sat.
  - sat clears only on reset or clear.
- FSM:
  - IDLE: first transfer -> RUN. A transfer with s_last in IDLE -> DRAIN directly.
  - RUN: transfer with s_last=1 -> DRAIN.
  - DRAIN: s_ready=0. Go to DONE when all pipeline valid bits are 0 (3 cycles after the last transfer).
  - DONE: done=1, outputs frozen, s_ready=0. clear -> IDLE.
- clear in any state:
  - Next cycle: pipeline valid bits 0, statistics 0, sat 0, state IDLE.
  - A sample presented in the same cycle as clear is not accepted, because s_ready=0.
- Reset mid-run: identical to clear. In-flight samples are discarded.
- Simultaneous s_last transfer and S3 update: both take effect. The DRAIN count starts from that edge.
- Back-to-back transfers are supported at 1 sample/cycle in RUN.

Decomposition:
- Shared package approx_err_pkg holds:
  - FSM state enum: IDLE, RUN, DRAIN, DONE.
  - Default widths W, CNT_W, SUM_W.
  - Saturating-add helper function.
- One sub-module, err_dist_stage: registered exact multiply plus absolute difference (S2/S3 datapath), parameterised by W.
- FSM and accumulators stay in the top module.

Test Plan:
- Exact match: 4 samples (3,5,y=15), (0,65535,y=0), (65535,65535,y=4294836225), (100,200,y=20000), last on 4th -> sample_count=4, err_count=0, sum_ed=0, max_ed=0, done 4 cycles after the last transfer edge (3-cycle latency plus the DRAIN -> DONE transition).
- Errors: (10,10,y=96), (7,9,y=70), (2,2,y=4, last) -> err_count=2, sum_ed=11, max_ed=7.
- Backpressure and last: after the s_last transfer, s_ready=0 through DRAIN and DONE. An extra valid sample is not counted. clear -> s_ready=1, all statistics 0.
- Mid-run clear: 5 samples back-to-back with clear asserted on the cycle after the 3rd transfer -> next cycle all statistics 0, IDLE, busy=0. No late pipeline update.
- Saturation: SUM_W=8, samples with ed=200 then ed=100 -> sum_ed=255, sat=1, max_ed=200. Reset -> sat=0.
- Throughput: 1000 random samples with an injected error model, s_valid held high, compared against a bench scoreboard -> exact match of all four statistics. No bubbles in RUN.

Source files
------------

// File: rtl/approx_err_pkg.sv
// Shared types, default widths and helpers for the
// approximate-multiplier error-statistics monitor.
package approx_err_pkg;

    localparam int W_DEF     = 16;
    localparam int CNT_W_DEF = 33;
    localparam int SUM_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic        ovf;
        logic [63:0] sum;
    } sat_sum_t;

    // Add two values and clamp at lim; ovf flags the clamp.
    function automatic sat_sum_t sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] lim
    );
        logic [64:0] s;
        sat_sum_t    r;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim}) begin
            r.ovf = 1'b1;
            r.sum = lim;
        end else begin
            r.ovf = 1'b0;
            r.sum = s[63:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/err_dist_stage.sv
// Registered exact product and registered absolute error
// distance between it and the approximate product.
module err_dist_stage #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear_i,
    input  logic           v_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [2*W-1:0] y_i,
    output logic           v_o,
    output logic [2*W-1:0] ed_o,
    output logic           neq_o
);

    logic           v2_q;
    logic           v3_q;
    logic [2*W-1:0] exact_q;
    logic [2*W-1:0] y2_q;
    logic [2*W-1:0] ed_q;
    logic           neq_q;
    logic [2*W-1:0] exact_d;
    logic [2*W-1:0] ed_d;

    assign exact_d = (2*W)'(a_i) * (2*W)'(b_i);
    assign ed_d    = (exact_q >= y2_q) ? (exact_q - y2_q)
                                       : (y2_q - exact_q);

    // Valid bits follow the data; reset and clear flush them.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v2_q <= v_i;
            v3_q <= v2_q;
        end
    end

    // Datapath registers; qualified downstream by the valid bits.
    always_ff @(posedge clk) begin
        exact_q <= exact_d;
        y2_q    <= y_i;
        ed_q    <= ed_d;
        neq_q   <= (ed_d != '0);
    end

    assign v_o   = v3_q;
    assign ed_o  = ed_q;
    assign neq_o = neq_q;

endmodule

// File: rtl/approx_mul_err_monitor.sv
// Error-statistics collector: streams operand pairs plus
// approximate product, accumulates count/errors/sum/max.
module approx_mul_err_monitor
    import approx_err_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_a,
    input  logic [W-1:0]     s_b,
    input  logic [2*W-1:0]   s_y,
    input  logic             s_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [SUM_W-1:0] sum_ed,
    output logic [2*W-1:0]   max_ed,
    output logic             sat
);

    localparam logic [63:0] CNT_LIM = (64'd1 << CNT_W) - 64'd1;
    localparam logic [63:0] SUM_LIM = (64'd1 << SUM_W) - 64'd1;

    state_e state_q;
    state_e state_d;

    logic           take;
    logic           pipe_busy;

    logic           v1_q;
    logic [W-1:0]   a1_q;
    logic [W-1:0]   b1_q;
    logic [2*W-1:0] y1_q;

    logic           ed_v;
    logic [2*W-1:0] ed;
    logic           neq;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [2*W-1:0]   max_q;
    logic [2*W-1:0]   max_d;
    logic             sat_q;
    logic             sat_d;

    sat_sum_t r_cnt;
    sat_sum_t r_err;
    sat_sum_t r_sum;
    logic     unused_hi;

    assign s_ready   = ((state_q == IDLE) || (state_q == RUN)) && !clear;
    assign take      = s_valid && s_ready;
    assign pipe_busy = v1_q || u_ed.v2_q || ed_v;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: run until s_last, drain the pipe, hold in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (take) state_d = s_last ? DRAIN : RUN;
            RUN:   if (take && s_last) state_d = DRAIN;
            DRAIN: if (!pipe_busy) state_d = DONE;
            DONE:  state_d = DONE;
        endcase
        if (clear) state_d = IDLE;
    end

    // S1: capture the accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= take;
        end
        a1_q <= s_a;
        b1_q <= s_b;
        y1_q <= s_y;
    end

    err_dist_stage #(
        .W (W)
    ) u_ed (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .v_i     (v1_q),
        .a_i     (a1_q),
        .b_i     (b1_q),
        .y_i     (y1_q),
        .v_o     (ed_v),
        .ed_o    (ed),
        .neq_o   (neq)
    );

    assign r_cnt = sat_add(64'(cnt_q), 64'd1, CNT_LIM);
    assign r_err = sat_add(64'(err_q), 64'(neq), CNT_LIM);
    assign r_sum = sat_add(64'(sum_q), 64'(ed), SUM_LIM);

    // Clamped bits above the output widths are always zero.
    assign unused_hi = ^{r_cnt, r_err, r_sum};

    // S3: fold one error distance into the statistics.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        sum_d = sum_q;
        max_d = max_q;
        sat_d = sat_q;
        if (ed_v) begin
            cnt_d = r_cnt.sum[CNT_W-1:0];
            err_d = r_err.sum[CNT_W-1:0];
            sum_d = r_sum.sum[SUM_W-1:0];
            max_d = (ed > max_q) ? ed : max_q;
            sat_d = sat_q | r_cnt.ovf | r_err.ovf | r_sum.ovf;
        end
    end

    // Statistics registers; clear wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_q <= '0;
            err_q <= '0;
            sum_q <= '0;
            max_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            sum_q <= sum_d;
            max_q <= max_d;
            sat_q <= sat_d;
        end
    end

    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign sample_count = cnt_q;
    assign err_count    = err_q;
    assign sum_ed       = sum_q;
    assign max_ed       = max_q;
    assign sat          = sat_q;

endmodule
